// File: rtl/if_fetch_stage.sv
// if_fetch_stage: fetch PC + imem capture FIFO with redirect flush; define IF_MISALIGN_CHECK_EN to fault misaligned redirects
module if_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc_addr,
  input  logic [31:0] imem_instruction,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val
);
  localparam int AW = $clog2(DEPTH);
`ifdef IF_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {RUN, HALT, MISAL} state_t;
`else
  typedef enum logic [1:0] {RUN, HALT} state_t;
`endif
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } entry_t;
  state_t        state, state_n;
  logic [63:0]   pc, pc_n;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  entry_t        mem [DEPTH];
  entry_t        head, wr_entry;
  logic          pop, push, push_ok;
  assign head      = mem[rd_ptr];
  assign out_valid = count != '0;
  assign pop       = out_valid & out_ready;
  assign push_ok   = (count < (AW+1)'(DEPTH)) | pop;
  assign pc_addr   = pc;
  assign out_pc       = out_valid ? head.pc : 64'h0;
  assign out_instr    = out_valid ? head.instr : 32'h00000013;
  assign out_exc_en   = out_valid & head.exc_en;
  assign out_exc_code = out_valid ? head.exc_code : 4'h0;
  assign out_exc_val  = out_valid ? head.exc_val : 64'h0;
  // next PC/state and push decision; redirect wins and never pushes
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    push     = 1'b0;
    wr_entry = '{pc, imem_instruction, imem_exc_en, imem_exc_code, imem_exc_val};
    if (redirect_en) begin
`ifdef IF_MISALIGN_CHECK_EN
      pc_n    = redirect_pc;
      state_n = (redirect_pc[1:0] != 2'b00) ? MISAL : RUN;
`else
      pc_n    = redirect_pc & ~64'h3;
      state_n = RUN;
`endif
    end else if (push_ok) begin
      case (state)
        RUN: begin
          push    = 1'b1;
          state_n = imem_exc_en ? HALT : RUN;
          pc_n    = imem_exc_en ? pc : pc + 64'd4;
        end
`ifdef IF_MISALIGN_CHECK_EN
        MISAL: begin
          push     = 1'b1;
          wr_entry = '{pc, 32'h00000013, 1'b1, 4'd0, pc};
          state_n  = HALT;
        end
`endif
        default: ;
      endcase
    end
  end
  // PC, state and FIFO pointers; redirect flushes the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      count  <= redirect_en ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
      rd_ptr <= redirect_en ? '0 : rd_ptr + AW'(pop);
      wr_ptr <= redirect_en ? '0 : wr_ptr + AW'(push);
    end
  end
  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios plus randomized run against a queue-based fetch model
module tb_if_fetch_stage;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int DEPTH = 2;
  logic        clk, rst, redirect_en, out_ready, exc_en;
  logic [63:0] redirect_pc, exc_val, pc_addr, out_pc, out_exc_val;
  logic [3:0]  exc_code, out_exc_code;
  logic [31:0] imem_instruction, out_instr;
  logic        out_valid, out_exc_en;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  code;
    logic [63:0] val;
  } ent_t;
  ent_t        q[$];
  logic [63:0] m_pc;
  bit          m_halt, m_misal;

  function automatic logic [31:0] word(input logic [63:0] a);
    logic [11:0] k;
    k = a[13:2] + 12'd1;
    return {k, 8'h00, k[4:0], 7'h13};
  endfunction

  assign imem_instruction = word(pc_addr);

  if_fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .pc_addr(pc_addr), .imem_instruction(imem_instruction), .imem_exc_en(exc_en),
    .imem_exc_code(exc_code), .imem_exc_val(exc_val), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_exc_en(out_exc_en), .out_exc_code(out_exc_code), .out_exc_val(out_exc_val));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    bit pop_m, can_push;
    pop_m = (q.size() != 0) && out_ready;
    if (rst) begin
      q.delete();
      m_pc = RESET_PC;
      m_halt = 0;
      m_misal = 0;
    end else if (redirect_en) begin
      q.delete();
      m_halt = 0;
`ifdef IF_MISALIGN_CHECK_EN
      m_misal = redirect_pc[1:0] != 2'b00;
      m_pc = redirect_pc;
`else
      m_misal = 0;
      m_pc = {redirect_pc[63:2], 2'b00};
`endif
    end else begin
      can_push = (q.size() < DEPTH) || pop_m;
      if (pop_m) void'(q.pop_front());
      if (!m_halt && can_push) begin
        if (m_misal) begin
          q.push_back('{m_pc, 32'h00000013, 1'b1, 4'd0, m_pc});
          m_halt = 1;
          m_misal = 0;
        end else begin
          q.push_back('{m_pc, word(m_pc), exc_en, exc_code, exc_val});
          if (exc_en) m_halt = 1;
          else m_pc = m_pc + 64'd4;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    cycle();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++;
    if (out_instr !== 32'h00000013) begin fails++; $display("FAIL reset_instr got %h exp 00000013", out_instr); end
    tests++;
    if (pc_addr !== RESET_PC) begin fails++; $display("FAIL reset_pc_addr got %h exp %h", pc_addr, RESET_PC); end
    tests++;
    if ({out_pc, out_exc_en, out_exc_code, out_exc_val} !== '0) begin
      fails++; $display("FAIL reset_fields got pc %h exc %b code %h val %h exp all 0", out_pc, out_exc_en, out_exc_code, out_exc_val);
    end
    rst = 0;
  endtask

  task automatic test_stream();
    logic [31:0] words[3] = '{32'h00100093, 32'h00200113, 32'h00300193};
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 64'(i * 4), words[i]}) begin
        fails++; $display("FAIL stream_%0d got v %b pc %h instr %h exp v 1 pc %h instr %h", i, out_valid, out_pc, out_instr, i * 4, words[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    rst = 1;
    cycle();
    rst = 0;
    out_ready = 0;
    repeat (5) cycle();
    tests++;
    if ({out_valid, out_pc, pc_addr} !== {1'b1, 64'h0, 64'h8}) begin
      fails++; $display("FAIL bp_hold got v %b pc %h addr %h exp v 1 pc 0 addr 8", out_valid, out_pc, pc_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({out_valid, out_pc} !== {1'b1, 64'(i * 4)}) begin
        fails++; $display("FAIL bp_drain_%0d got v %b pc %h exp v 1 pc %h", i, out_valid, out_pc, i * 4);
      end
      out_ready = 1;
      cycle();
    end
  endtask

  task automatic test_redirect_full();
    out_ready = 0;
    repeat (2) cycle();
    out_ready = 1;
    redirect_en = 1;
    redirect_pc = 64'h80;
    cycle();
    redirect_en = 0;
    tests++;
    if ({out_valid, pc_addr} !== {1'b0, 64'h80}) begin
      fails++; $display("FAIL redir_flush got v %b addr %h exp v 0 addr 80", out_valid, pc_addr);
    end
    cycle();
    tests++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 64'h80, 32'h02100093}) begin
      fails++; $display("FAIL redir_target got v %b pc %h instr %h exp v 1 pc 80 instr 02100093", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_fault();
    redirect_en = 1;
    redirect_pc = 64'h2000;
    cycle();
    redirect_en = 0;
    exc_en = 1;
    exc_code = 4'd1;
    exc_val = 64'h2000;
    cycle();
    exc_en = 0;
    tests++;
    if ({out_valid, out_pc, out_exc_en, out_exc_code, out_exc_val, pc_addr} !== {1'b1, 64'h2000, 1'b1, 4'd1, 64'h2000, 64'h2000}) begin
      fails++; $display("FAIL fault_entry got v %b pc %h exc %b code %h val %h addr %h exp v 1 pc 2000 exc 1 code 1 val 2000 addr 2000",
                        out_valid, out_pc, out_exc_en, out_exc_code, out_exc_val, pc_addr);
    end
    repeat (3) cycle();
    tests++;
    if ({out_valid, pc_addr} !== {1'b0, 64'h2000}) begin
      fails++; $display("FAIL fault_halt got v %b addr %h exp v 0 addr 2000", out_valid, pc_addr);
    end
    redirect_en = 1;
    redirect_pc = 64'h0;
    cycle();
    redirect_en = 0;
    cycle();
    tests++;
    if ({out_valid, out_pc, out_exc_en} !== {1'b1, 64'h0, 1'b0}) begin
      fails++; $display("FAIL fault_resume got v %b pc %h exc %b exp v 1 pc 0 exc 0", out_valid, out_pc, out_exc_en);
    end
  endtask

  task automatic test_misalign();
    redirect_en = 1;
    redirect_pc = 64'h82;
    cycle();
    redirect_en = 0;
    out_ready = 0;
`ifdef IF_MISALIGN_CHECK_EN
    tests++;
    if (pc_addr !== 64'h82) begin fails++; $display("FAIL misal_addr got %h exp 82", pc_addr); end
    cycle();
    tests++;
    if ({out_valid, out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val} !== {1'b1, 64'h82, 32'h00000013, 1'b1, 4'd0, 64'h82}) begin
      fails++; $display("FAIL misal_entry got v %b pc %h instr %h exc %b code %h val %h exp v 1 pc 82 instr 13 exc 1 code 0 val 82",
                        out_valid, out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val);
    end
    out_ready = 1;
    cycle();
    tests++;
    if ({out_valid, pc_addr} !== {1'b0, 64'h82}) begin
      fails++; $display("FAIL misal_halt got v %b addr %h exp v 0 addr 82", out_valid, pc_addr);
    end
`else
    tests++;
    if (pc_addr !== 64'h80) begin fails++; $display("FAIL misal_addr got %h exp 80", pc_addr); end
    cycle();
    tests++;
    if ({out_valid, out_pc, out_exc_en} !== {1'b1, 64'h80, 1'b0}) begin
      fails++; $display("FAIL misal_fetch got v %b pc %h exc %b exp v 1 pc 80 exc 0", out_valid, out_pc, out_exc_en);
    end
    out_ready = 1;
`endif
  endtask

  task automatic test_reset_mid();
    rst = 1;
    cycle();
    rst = 0;
    out_ready = 0;
    repeat (2) cycle();
    tests++;
    if ({out_valid, pc_addr} !== {1'b1, 64'h8}) begin
      fails++; $display("FAIL rstmid_fill got v %b addr %h exp v 1 addr 8", out_valid, pc_addr);
    end
    rst = 1;
    cycle();
    rst = 0;
    tests++;
    if ({out_valid, pc_addr, out_instr} !== {1'b0, RESET_PC, 32'h00000013}) begin
      fails++; $display("FAIL rstmid_clear got v %b addr %h instr %h exp v 0 addr %h instr 13", out_valid, pc_addr, out_instr, RESET_PC);
    end
  endtask

  task automatic test_random();
    ent_t e;
    bit   ev;
    for (int i = 0; i < 2000; i++) begin
      out_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      redirect_en = $urandom_range(0, 29) == 0;
      redirect_pc = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {32'h0, $urandom};
      exc_en = $urandom_range(0, 19) == 0;
      exc_code = 4'($urandom);
      exc_val = {$urandom, $urandom};
      cycle();
      ev = q.size() != 0;
      e = ev ? q[0] : '{64'h0, 32'h00000013, 1'b0, 4'd0, 64'h0};
      tests++;
      if ({out_valid, pc_addr, out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val} !==
          {ev, m_pc, e.pc, e.instr, e.exc_en, e.code, e.val}) begin
        fails++;
        $display("FAIL random_%0d got v %b addr %h pc %h instr %h exc %b code %h val %h exp v %b addr %h pc %h instr %h exc %b code %h val %h",
                 i, out_valid, pc_addr, out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val,
                 ev, m_pc, e.pc, e.instr, e.exc_en, e.code, e.val);
      end
    end
    rst = 0;
    redirect_en = 0;
    exc_en = 0;
  endtask

  initial begin
    rst = 1;
    redirect_en = 0;
    redirect_pc = '0;
    out_ready = 0;
    exc_en = 0;
    exc_code = '0;
    exc_val = '0;
    m_pc = RESET_PC;
    m_halt = 0;
    m_misal = 0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_fault();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
